// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for the burst memory.
//   access_size_t : encoding of the access_size port (1/4/8/16 beats)
//   state_t       : burst FSM states (IDLE, READ, WRITE)
//   beats_of()    : number of beats in a burst of a given access size
package burst_mem_pkg;

  typedef enum logic [1:0] {
    SIZE_1  = 2'b00,
    SIZE_4  = 2'b01,
    SIZE_8  = 2'b10,
    SIZE_16 = 2'b11
  } access_size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  function automatic logic [4:0] beats_of(input access_size_t s);
    case (s)
      SIZE_1:  return 5'd1;
      SIZE_4:  return 5'd4;
      SIZE_8:  return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/burst_memory.sv
// Byte-addressed burst memory with big-endian beat packing.
// Ports:
//   clk          : sole clock, rising edge
//   reset        : synchronous, active-high; aborts any burst, keeps memory contents
//   enable       : request strobe, only looked at in IDLE
//   read_write   : 1 = read burst, 0 = write burst
//   access_size  : 00/01/10/11 = 1/4/8/16 beats
//   address      : start byte address (wraps modulo DEPTH_BYTES, no alignment needed)
//   data_in      : write beat data, one beat per cycle from the acceptance edge on
//   data_out     : registered read beat, holds the last beat when idle
//   data_valid   : data_out carries a fresh read beat this cycle
//   busy         : state is not IDLE
//   debug_state  : current FSM state
// Handshake: a request is accepted on any rising edge where the FSM is IDLE and
// enable is high; while busy all request inputs are ignored. Write beat i is taken
// from data_in at acceptance edge + i; read beat i appears on data_out with
// data_valid high after acceptance edge + 1 + i. There is no back-pressure.
module burst_memory
  import burst_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 1048576,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_write,
  input  logic [1:0]        access_size,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic [1:0]        debug_state
);

  localparam int BYTES  = DATA_W / 8;
  localparam int MEM_AW = $clog2(DEPTH_BYTES);

  logic [7:0]        r_mem [DEPTH_BYTES];
  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_cnt;

  logic              w_accept;
  logic [3:0]        w_last_idx;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;

  // Byte j of a beat starting at a, wrapped into the array.
  function automatic logic [MEM_AW-1:0] byte_idx(input logic [ADDR_W-1:0] a, input int j);
    return MEM_AW'(a + ADDR_W'(j));
  endfunction

  // Unpack: lane j of a beat, lane 0 being the most significant byte.
  function automatic logic [7:0] byte_lane(input logic [DATA_W-1:0] d, input int j);
    return d[DATA_W-1-8*j -: 8];
  endfunction

  // Pack: gather BYTES consecutive bytes starting at a into one big-endian beat.
  function automatic logic [DATA_W-1:0] pack_beat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int j = 0; j < BYTES; j++) begin
      v[DATA_W-1-8*j -: 8] = r_mem[byte_idx(a, j)];
    end
    return v;
  endfunction

  assign w_accept   = (r_state == ST_IDLE) && enable;
  assign w_last_idx = 4'(beats_of(access_size_t'(access_size)) - 5'd1);
  assign busy        = (r_state != ST_IDLE);
  assign debug_state = r_state;

  // Beat 0 of a write lands on the acceptance edge straight from the ports;
  // later beats use the address register. Reset suppresses the write.
  assign w_we    = !reset && ((w_accept && !read_write) || (r_state == ST_WRITE));
  assign w_waddr = (r_state == ST_IDLE) ? address : r_addr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // r_cnt: in READ, beats left after the current one; in WRITE, beats left
  // including the current one (beat 0 was already written at acceptance).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          if (read_write)             w_next_state = ST_READ;
          else if (w_last_idx != '0)  w_next_state = ST_WRITE;
        end
      end
      ST_READ:  if (r_cnt == 4'd0) w_next_state = ST_IDLE;
      ST_WRITE: if (r_cnt == 4'd1) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_cnt  <= w_last_idx;
            r_addr <= read_write ? address : address + ADDR_W'(BYTES);
          end
        end
        ST_READ: begin
          data_out   <= pack_beat(r_addr);
          data_valid <= 1'b1;
          r_addr     <= r_addr + ADDR_W'(BYTES);
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        ST_WRITE: begin
          r_addr <= r_addr + ADDR_W'(BYTES);
          r_cnt  <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory array has no reset so contents survive a burst abort.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int j = 0; j < BYTES; j++) begin
        r_mem[byte_idx(w_waddr, j)] <= byte_lane(data_in, j);
      end
    end
  end

endmodule

// File: doc/burst_memory.md
BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; multiple of 8, range 8..128.
REQ-002 SHALL have parameter DEPTH_BYTES, default 1048576, byte capacity; power of two.
REQ-003 SHALL have parameter ADDR_W, default 32, address bus width in bits.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1, request strobe, sampled only in IDLE.
REQ-007 SHALL have port read_write, input, 1, 1 = read burst, 0 = write burst.
REQ-008 SHALL have port access_size, input, 2, burst length: 00 = 1, 01 = 4, 10 = 8, 11 = 16 beats.
REQ-009 SHALL have port address, input, ADDR_W, start byte address.
REQ-010 SHALL have port data_in, input, DATA_W, write beat data.
REQ-011 SHALL have port data_out, output, DATA_W, read beat data, registered.
REQ-012 SHALL have port data_valid, output, 1, data_out holds a valid read beat this cycle.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL store bytes; each beat spans BYTES = DATA_W/8 consecutive bytes, big-endian: lowest address maps to data[DATA_W-1 -: 8].
REQ-015 SHALL wrap every byte address modulo DEPTH_BYTES, both within a beat and across beats; no alignment is required.
REQ-016 SHALL implement FSM IDLE, READ, WRITE; IDLE + enable + read_write=1 -> READ; IDLE + enable + read_write=0 -> WRITE, or stay IDLE if the burst is 1 beat.
REQ-017 SHALL, on acceptance at edge k, latch address and a beat counter of N-1.
REQ-018 SHALL, for reads, register beat i to data_out and set data_valid at edge k+1+i, with the address advancing by BYTES per beat; beats are back-to-back with no bubbles.
REQ-019 SHALL return READ -> IDLE on the edge that emits the last beat; data_valid drops at the next edge unless a new beat is emitted.
REQ-020 SHALL, for writes, write beat 0 from data_in at acceptance edge k and beat i at edge k+i; the master presents one beat per cycle.
REQ-021 SHALL return WRITE -> IDLE on the edge that writes beat N-1.
REQ-022 SHALL ignore enable, read_write, access_size and address while busy; a request only takes effect in IDLE.
REQ-023 SHALL accept a new request in the first IDLE cycle after a burst ends, with zero turnaround.
REQ-024 SHALL hold data_out at the last beat and data_valid at 0 when no beat is emitted.
REQ-025 SHALL make a read following a write to the same bytes return the new data.

Reset
REQ-026 SHALL, on reset, set state to IDLE, busy to 0, data_valid to 0, data_out to 0 and the counter to 0.
REQ-027 SHALL have reset take priority over enable on the same edge and abort any burst in progress; remaining beats are not written or emitted.
REQ-028 SHALL leave memory array contents unchanged on reset.

Structure
REQ-029 SHALL place in shared package burst_mem_pkg: the access_size enum, the FSM state enum, and the function beats_of(access_size) returning 1/4/8/16.
REQ-030 SHALL be a single module; the byte-lane pack/unpack logic is a local function; no sub-module.

Verification
REQ-031 SHALL cover: 1-beat write of 0xDEADBEEF to 0x100, then 1-beat read of 0x100 -> data_out 0xDEADBEEF with data_valid high for exactly 1 cycle; byte 0x100 = 0xDE.
REQ-032 SHALL cover: 4-beat write of 0x11111111..0x44444444 at 0x200, then 4-beat read -> 4 consecutive valid beats in order; busy high for 4 cycles.
REQ-033 SHALL cover: 16-beat read at DEPTH_BYTES-8 -> beats 2..15 come from 0x0..0x37 (wrap).
REQ-034 SHALL cover: enable pulsed with a write request during a 8-beat read -> memory unchanged, read completes all 8 beats.
REQ-035 SHALL cover: reset asserted at beat 2 of an 8-beat write -> beats 0-1 written, beats 2-7 untouched, busy = 0 the next cycle.
REQ-036 SHALL cover: DATA_W = 64 instance, 1-beat read at unaligned 0x3 -> bytes 0x3..0xA big-endian.
